// File: rtl/spif_pkg.sv
// spif_pkg: shared SpiNNaker packet widths, header bit positions and parity helper.
//   HDR_BITS/KEY_BITS/PLD_BITS/PACKET_BITS : packet field widths
//   PARITY_BIT/PLD_BIT/TYPE_LSB            : header bit positions
//   mc_parity()                            : parity bit that makes the packet popcount odd
package spif_pkg;
    localparam int HDR_BITS    = 8;
    localparam int KEY_BITS    = 32;
    localparam int PLD_BITS    = 32;
    localparam int PACKET_BITS = 72;
    localparam int PARITY_BIT  = 0;
    localparam int PLD_BIT     = 1;
    localparam int TYPE_LSB    = 6;
    typedef enum logic [1:0] {PKT_MC = 2'b00, PKT_P2P = 2'b01, PKT_NN = 2'b10, PKT_FR = 2'b11} pkt_type_t;
    // hdr_wo_parity carries 0 in the parity position, so the result is the bit
    // that brings the total count of ones to an odd number.
    function automatic logic mc_parity(input logic [KEY_BITS-1:0] key,
                                       input logic [PLD_BITS-1:0] payload,
                                       input logic [HDR_BITS-1:0] hdr_wo_parity);
        return ~(^{key, payload, hdr_wo_parity});
    endfunction
endpackage

// File: rtl/pkt_field_mapper.sv
// pkt_field_mapper: combinational routing-key generation from an event word.
//   base_key  : programmable base key
//   evt_data  : event word
//   field_msk : per-register field masks
//   field_sft : per-register signed shifts (>=0 right, <0 left)
//   key       : base_key ORed with every masked and shifted field
module pkt_field_mapper import spif_pkg::*; #(
    parameter int NUM_MREGS = 4
) (
    input  logic [KEY_BITS-1:0] base_key,
    input  logic [31:0]         evt_data,
    input  logic [31:0]         field_msk [NUM_MREGS],
    input  logic [5:0]          field_sft [NUM_MREGS],
    output logic [KEY_BITS-1:0] key
);
    logic [31:0] field;
    logic [5:0]  amt;
    always_comb begin
        key   = base_key;
        field = '0;
        amt   = '0;
        for (int i = 0; i < NUM_MREGS; i++) begin
            field = evt_data & field_msk[i];
            // magnitude of -32 is 6'd32, which still shifts everything out
            amt   = field_sft[i][5] ? 6'(-field_sft[i]) : field_sft[i];
            key   = key | (field_sft[i][5] ? field << amt : field >> amt);
        end
    end
endmodule

// File: rtl/pkt_assembler.sv
// pkt_assembler: turns 32-bit events into 72-bit multicast packets behind a one-stage output register.
//   clk_tb, reset_tb (async, active-high)
//   mp_key_in, field_msk_in, field_sft_in : key configuration
//   evt_data_in/evt_vld_in/evt_rdy_out    : event input handshake
//   pkt_data_out/pkt_vld_out/pkt_rdy_in   : packet output handshake
module pkt_assembler #(
    parameter int PACKET_BITS = 72,
    parameter int NUM_MREGS   = 4
) (
    input  logic                   clk_tb,
    input  logic                   reset_tb,
    input  logic [31:0]            mp_key_in,
    input  logic [31:0]            field_msk_in [NUM_MREGS],
    input  logic [5:0]             field_sft_in [NUM_MREGS],
    input  logic [31:0]            evt_data_in,
    input  logic                   evt_vld_in,
    output logic                   evt_rdy_out,
    output logic [PACKET_BITS-1:0] pkt_data_out,
    output logic                   pkt_vld_out,
    input  logic                   pkt_rdy_in
);
    import spif_pkg::*;

    logic [KEY_BITS-1:0] key;
    logic [HDR_BITS-1:0] hdr;
    logic                accept;

    pkt_field_mapper #(.NUM_MREGS(NUM_MREGS)) u_mapper (
        .base_key  (mp_key_in),
        .evt_data  (evt_data_in),
        .field_msk (field_msk_in),
        .field_sft (field_sft_in),
        .key       (key)
    );

    always_comb begin
        hdr                 = '0;
        hdr[TYPE_LSB +: 2]  = PKT_MC;
        hdr[PLD_BIT]        = 1'b0;
        hdr[PARITY_BIT]     = mc_parity(key, PLD_BITS'(0), hdr);
    end

    // held low during reset so no handshake can complete against a register being cleared
    assign evt_rdy_out = !reset_tb && (!pkt_vld_out || pkt_rdy_in);
    assign accept      = evt_vld_in && evt_rdy_out;

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            pkt_vld_out  <= 1'b0;
            pkt_data_out <= '0;
        end else if (accept) begin
            pkt_vld_out  <= 1'b1;
            pkt_data_out <= PACKET_BITS'({PLD_BITS'(0), key, hdr});
        end else if (pkt_rdy_in) begin
            pkt_vld_out  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pkt_assembler.sv
// tb_pkt_assembler: vector table, streaming scoreboard, backpressure and async reset checks for pkt_assembler.
module tb_pkt_assembler;
    logic        clk_tb = 1'b0;
    logic        reset_tb = 1'b1;
    logic [31:0] mp_key_in = '0;
    logic [31:0] field_msk_in [4];
    logic [5:0]  field_sft_in [4];
    logic [31:0] evt_data_in = '0;
    logic        evt_vld_in = 1'b0;
    logic        evt_rdy_out;
    logic [71:0] pkt_data_out;
    logic        pkt_vld_out;
    logic        pkt_rdy_in = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc_n = 0;
    int out_n = 0;
    logic [71:0] sb [$];

    pkt_assembler #(.PACKET_BITS(72), .NUM_MREGS(4)) dut (
        .clk_tb       (clk_tb),
        .reset_tb     (reset_tb),
        .mp_key_in    (mp_key_in),
        .field_msk_in (field_msk_in),
        .field_sft_in (field_sft_in),
        .evt_data_in  (evt_data_in),
        .evt_vld_in   (evt_vld_in),
        .evt_rdy_out  (evt_rdy_out),
        .pkt_data_out (pkt_data_out),
        .pkt_vld_out  (pkt_vld_out),
        .pkt_rdy_in   (pkt_rdy_in)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bit-level reference: output bit j takes masked source bit j+s when it exists
    function automatic logic [71:0] model(input logic [31:0] ev);
        logic [31:0] k;
        logic [31:0] v;
        int s, src;
        k = mp_key_in;
        for (int i = 0; i < 4; i++) begin
            v = ev & field_msk_in[i];
            s = int'($signed(field_sft_in[i]));
            for (int j = 0; j < 32; j++) begin
                src = j + s;
                if (src >= 0 && src < 32 && v[src]) k[j] = 1'b1;
            end
        end
        return {32'h0, k, 7'b0, ($countones(k) % 2 == 0)};
    endfunction

    // inputs only change at posedge+1, so the negedge sees what the next edge will see
    always @(negedge clk_tb) begin
        if (reset_tb) sb.delete();
        else begin
            if (pkt_vld_out && pkt_rdy_in) begin
                out_n++;
                if (sb.size() == 0) chk("sb_unexpected_pkt", pkt_data_out, 72'hx);
                else chk("sb_pkt", pkt_data_out, sb.pop_front());
            end
            if (evt_vld_in && evt_rdy_out) begin
                acc_n++;
                sb.push_back(model(evt_data_in));
            end
        end
    end

    typedef struct {
        logic [31:0]      key;
        logic [3:0][31:0] msk;
        logic [3:0][5:0]  sft;
        logic [31:0]      evt;
        logic [71:0]      exp;
    } vec_t;

    vec_t vecs [7];

    task automatic set_cfg(input logic [31:0] k, input logic [3:0][31:0] m, input logic [3:0][5:0] s);
        mp_key_in = k;
        for (int i = 0; i < 4; i++) begin
            field_msk_in[i] = m[i];
            field_sft_in[i] = s[i];
        end
    endtask

    initial begin
        logic [71:0] held;
        logic        acc;
        vecs[0] = '{32'hee000000, {32'h0, 32'h0, 32'h000000ff, 32'h00ff0000}, {6'd0, 6'd0, 6'h38, 6'd16}, 32'h00123456, 72'h00000000_ee005612_01};
        vecs[1] = '{32'hee000000, {32'h0, 32'h0, 32'h000000ff, 32'h00ff0000}, {6'd0, 6'd0, 6'h38, 6'd16}, 32'h00000000, 72'h00000000_ee000000_01};
        vecs[2] = '{32'hee000000, {32'h0, 32'h0, 32'h000000ff, 32'h00ff0000}, {6'd0, 6'd0, 6'h38, 6'd16}, 32'h00000001, 72'h00000000_ee000100_00};
        vecs[3] = '{32'h0, {32'h0, 32'h0, 32'h0, 32'hffffffff}, {6'd0, 6'd0, 6'd0, 6'd31}, 32'h80000000, 72'h00000000_00000001_00};
        vecs[4] = '{32'h0, {32'h0, 32'h0, 32'h0, 32'hffffffff}, {6'd0, 6'd0, 6'd0, 6'h20}, 32'h00000001, 72'h00000000_00000000_01};
        vecs[5] = '{32'h12345678, {32'h0, 32'h0, 32'h0, 32'h0}, {6'd3, 6'h3c, 6'd7, 6'h21}, 32'hffffffff, 72'h00000000_12345678_00};
        vecs[6] = '{32'h0, {32'h0000000f, 32'h0000ff00, 32'h0, 32'h0}, {6'h24, 6'd4, 6'd0, 6'd0}, 32'h0000ab0c, 72'h00000000_c0000ab0_00};
        set_cfg(vecs[0].key, vecs[0].msk, vecs[0].sft);
        pkt_rdy_in = 1'b1;
        #12;
        chk("reset_vld", {71'b0, pkt_vld_out}, 72'd0);
        chk("reset_data", pkt_data_out, 72'd0);
        chk("reset_rdy", {71'b0, evt_rdy_out}, 72'd0);
        @(posedge clk_tb); #1;
        reset_tb = 1'b0;
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].key, vecs[v].msk, vecs[v].sft);
            evt_data_in = vecs[v].evt;
            evt_vld_in  = 1'b1;
            @(posedge clk_tb); #1;
            chk($sformatf("vec%0d_vld", v), {71'b0, pkt_vld_out}, 72'd1);
            chk($sformatf("vec%0d_pkt", v), pkt_data_out, vecs[v].exp);
        end
        evt_vld_in = 1'b0;
        @(posedge clk_tb); #1;
        chk("idle_vld", {71'b0, pkt_vld_out}, 72'd0);

        // streaming with a 3-cycle stall; config changes mid-stall
        set_cfg(vecs[0].key, vecs[0].msk, vecs[0].sft);
        evt_data_in = 32'd0;
        evt_vld_in  = 1'b1;
        held = '0;
        for (int c = 0; c < 30; c++) begin
            pkt_rdy_in = !(c >= 10 && c < 13);
            if (c == 11) mp_key_in = 32'h11000000;
            @(negedge clk_tb);
            acc = evt_vld_in && evt_rdy_out;
            if (c == 10) held = pkt_data_out;
            if (c >= 10 && c < 13) chk($sformatf("stall%0d_rdy", c), {71'b0, evt_rdy_out}, 72'd0);
            @(posedge clk_tb); #1;
            if (c >= 10 && c < 13) chk($sformatf("stall%0d_frozen", c), pkt_data_out, held);
            if (acc) evt_data_in = evt_data_in + 32'd1;
        end
        evt_vld_in = 1'b0;
        pkt_rdy_in = 1'b1;
        repeat (5) @(posedge clk_tb);
        #1;
        chk("drain_sb_empty", 72'(sb.size()), 72'd0);
        chk("drain_counts", 72'(acc_n), 72'(out_n));
        chk("drain_accepted", 72'(acc_n), 72'd34);
        chk("drain_vld", {71'b0, pkt_vld_out}, 72'd0);

        // async reset while a packet is pending
        set_cfg(vecs[0].key, vecs[0].msk, vecs[0].sft);
        evt_data_in = 32'h00123456;
        evt_vld_in  = 1'b1;
        pkt_rdy_in  = 1'b0;
        @(posedge clk_tb); #1;
        chk("pre_reset_vld", {71'b0, pkt_vld_out}, 72'd1);
        #2;
        reset_tb   = 1'b1;
        pkt_rdy_in = 1'b1;
        #1;
        chk("async_reset_vld", {71'b0, pkt_vld_out}, 72'd0);
        chk("async_reset_data", pkt_data_out, 72'd0);
        chk("async_reset_rdy", {71'b0, evt_rdy_out}, 72'd0);
        @(posedge clk_tb); #1;
        chk("held_reset_vld", {71'b0, pkt_vld_out}, 72'd0);
        reset_tb   = 1'b0;
        evt_vld_in = 1'b0;
        @(posedge clk_tb); #1;
        chk("post_reset_vld", {71'b0, pkt_vld_out}, 72'd0);
        chk("post_reset_rdy", {71'b0, evt_rdy_out}, 72'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_assembler.md
Name: pkt_assembler

Overview:
- Converts 32-bit input events into 72-bit SpiNNaker multicast packets, one packet per accepted event.
- The routing key is a programmable base key, ORed with up to NUM_MREGS masked and shifted fields extracted from the event.
- Mask, shift and key values come directly from the register bank.
- Sits between the event input stream and the packet router.
- Both sides use valid/ready handshakes.

Parameters:
- PACKET_BITS, 72: output packet width, laid out as {payload[31:0], key[31:0], header[7:0]}.
- NUM_MREGS, 4: number of mask/shift field-extraction registers.

Ports:
- clk_tb  input  1  clock; all state changes on its rising edge.
- reset_tb  input  1  reset; asynchronous, active-high.
- mp_key_in  input  32  base routing key.
- field_msk_in  input  32 x NUM_MREGS  unpacked array of field masks.
- field_sft_in  input  6 x NUM_MREGS  unpacked array of signed field shifts.
- evt_data_in  input  32  event word.
- evt_vld_in  input  1  event valid.
- evt_rdy_out  output  1  event ready.
- pkt_data_out  output  PACKET_BITS  assembled packet.
- pkt_vld_out  output  1  packet valid.
- pkt_rdy_in  input  1  packet ready.

Behaviour:
- Reset (async): pkt_vld_out=0, pkt_data_out=0.
- evt_rdy_out is combinational: evt_rdy_out = !pkt_vld_out || pkt_rdy_in. It is 0 while reset_tb is asserted.
- An event is accepted when evt_vld_in && evt_rdy_out at a rising edge.
- Latency: 1 cycle. The packet is registered on the accepting edge, and pkt_vld_out=1 from that edge.
- Full throughput: with pkt_rdy_in=1 held high, one packet is produced per cycle.
- Output register behaviour:
  - Cleared (pkt_vld_out<=0) on pkt_rdy_in && !accept.
  - Simultaneous output and input handshake: the register is reloaded with the new packet.
  - pkt_data_out stays stable while pkt_vld_out && !pkt_rdy_in.
- Key computation uses config values sampled combinationally on the accepting edge:
  - key = mp_key_in | OR over i of f(i).
  - f(i) = (evt_data_in & field_msk_in[i]) shifted by s = signed(field_sft_in[i]), range -32..31.
  - s >= 0: logical right shift by s. s < 0: logical left shift by -s.
  - Results are truncated to 32 bits.
  - A mask of 0 contributes nothing.
- Header[7:0]:
  - bits[7:6] = 2'b00 (multicast).
  - bits[5:2] = 0.
  - bit1 = 0 (no payload).
  - bit0 = parity, chosen so the popcount of the whole 72-bit packet is odd.
- Payload field = 32'h0.
- Reset mid-operation: any pending packet is discarded and no partial handshake survives.
- Config changes apply only to events accepted after the change. An already registered packet is unaffected.

Decomposition:
- Shared package spif_pkg holds:
  - localparams HDR_BITS=8, KEY_BITS=32, PLD_BITS=32, PACKET_BITS=72.
  - Header bit indices: PARITY_BIT=0, PLD_BIT=1, TYPE_LSB=6.
  - Function mc_parity(key, payload, hdr_wo_parity).
- One natural sub-module, pkt_field_mapper: combinational key generation from the event and the mask/shift arrays.
- The top level holds the handshake and output register.

Test Plan:
- Config: key 0xee000000; msk0 0x00ff0000, sft0 16; msk1 0x000000ff, sft1 -8; others 0. Event 0x00123456 -> key 0xee005612, pkt_data_out = 72'h00000000_ee005612_01, one cycle after accept.
- Same config, event 0x00000000 -> key 0xee000000, header 0x01; event 0x00000001 -> key 0xee000100, header 0x00.
- Incrementing events 0,1,2,... with evt_vld and pkt_rdy held high from reset release -> one packet per cycle, in order, none dropped or duplicated; the number of accepted events equals the number of output handshakes.
- Backpressure: drop pkt_rdy_in for 3 cycles -> evt_rdy_out=0, pkt_data_out frozen; on release, flow resumes with the next event.
- Shift extremes: msk0 0xffffffff, sft0 31, event 0x80000000 -> key bit0 set. sft0 -32, event 0x1 -> contribution 0.
- Assert reset_tb while pkt_vld_out=1 -> pkt_vld_out and pkt_data_out go to 0 immediately (asynchronously), and evt_rdy_out=0 until release.
